// File: rtl/up_down_limit_counter_pkg.sv
// counter_pkg: shared boundary-mode constants and FSM state encoding for
// the up/down limit counter and its step calculator.
package counter_pkg;

  // Boundary behaviour selected by the 2-bit mode input; 2'b11 behaves as wrap.
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // RUN steps normally; HALT is only entered by a one-shot boundary hit.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/up_down_limit_step_calc.sv
// up_down_limit_step_calc: purely combinational next-count calculation for
// one enabled step, including boundary detection and terminal-count intent.
// Arithmetic is done one bit wider than the count so that carry past the top
// and borrow below zero are both seen as boundary hits.
module up_down_limit_step_calc
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_count,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_up,
  input  logic [WIDTH-1:0]  i_lim_min,
  input  logic [WIDTH-1:0]  i_lim_max,
  input  logic [1:0]        i_mode,
  output logic [WIDTH-1:0]  o_next_count,
  output logic              o_hit_boundary,
  output logic              o_tc_next
);

  logic [WIDTH:0] w_step_ext;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_up_hit;
  logic           w_down_hit;

  assign w_step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
  assign w_sum      = {1'b0, i_count} + w_step_ext;
  assign w_diff     = {1'b0, i_count} - w_step_ext;
  // A set top bit on the difference is a borrow, i.e. the step went below zero.
  assign w_up_hit   = (w_sum >= {1'b0, i_lim_max});
  assign w_down_hit = w_diff[WIDTH] || (w_diff[WIDTH-1:0] <= i_lim_min);

  // Select next count and terminal-count intent for the current direction and mode.
  always_comb begin
    o_next_count   = i_count;
    o_hit_boundary = 1'b0;
    o_tc_next      = 1'b0;
    if (i_step == {STEP_W{1'b0}}) begin
      // A zero step never moves the count and never signals a boundary.
      o_next_count   = i_count;
      o_hit_boundary = 1'b0;
      o_tc_next      = 1'b0;
    end else if (i_up) begin
      if (w_up_hit) begin
        o_hit_boundary = 1'b1;
        case (i_mode)
          MODE_SAT: begin
            o_next_count = i_lim_max;
            o_tc_next    = (i_count < i_lim_max);
          end
          MODE_ONESHOT: begin
            o_next_count = i_lim_max;
            o_tc_next    = 1'b1;
          end
          default: begin
            // Wrap and the reserved encoding: land on the limit, then wrap.
            o_next_count = (i_count == i_lim_max) ? i_lim_min : i_lim_max;
            o_tc_next    = 1'b1;
          end
        endcase
      end else begin
        o_next_count = w_sum[WIDTH-1:0];
      end
    end else begin
      if (w_down_hit) begin
        o_hit_boundary = 1'b1;
        case (i_mode)
          MODE_SAT: begin
            o_next_count = i_lim_min;
            o_tc_next    = (i_count > i_lim_min);
          end
          MODE_ONESHOT: begin
            o_next_count = i_lim_min;
            o_tc_next    = 1'b1;
          end
          default: begin
            o_next_count = (i_count == i_lim_min) ? i_lim_max : i_lim_min;
            o_tc_next    = 1'b1;
          end
        endcase
      end else begin
        o_next_count = w_diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/up_down_limit_counter.sv
// up_down_limit_counter: parametrised up/down counter with load, programmable
// step and inclusive limits. Boundary handling (wrap / saturate / one-shot)
// lives in the step calculator; this level owns the registers, the
// clear > load > step > hold priority and the one-shot RUN/HALT machine.
module up_down_limit_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [WIDTH-1:0]  lim_min,
  input  logic [WIDTH-1:0]  lim_max,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              at_min,
  output logic              at_max,
  output logic              done,
  output logic              cfg_err
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic [WIDTH-1:0] w_next_count;
  logic             w_hit_boundary;
  logic             w_tc_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_cfg_err;

  up_down_limit_step_calc #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step_calc (
    .i_count        (r_count),
    .i_step         (step),
    .i_up           (up),
    .i_lim_min      (lim_min),
    .i_lim_max      (lim_max),
    .i_mode         (mode),
    .o_next_count   (w_next_count),
    .o_hit_boundary (w_hit_boundary),
    .o_tc_next      (w_tc_next)
  );

  assign w_cfg_err = (lim_min > lim_max);

  // Clamp the load value into the programmed [lim_min, lim_max] window.
  always_comb begin
    w_load_clamped = load_value;
    if (load_value < lim_min) begin
      w_load_clamped = lim_min;
    end else if (load_value > lim_max) begin
      w_load_clamped = lim_max;
    end else begin
      w_load_clamped = load_value;
    end
  end

  // Count, terminal-count and one-shot state registers with command priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {WIDTH{1'b0}};
      r_tc    <= 1'b0;
      r_state <= ST_RUN;
    end else if (w_cfg_err) begin
      // Inconsistent limits freeze everything, including clear and load.
      r_tc <= 1'b0;
    end else if (clear) begin
      r_count <= up ? lim_min : lim_max;
      r_tc    <= 1'b0;
      r_state <= ST_RUN;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
      r_state <= ST_RUN;
    end else if (r_state == ST_HALT) begin
      // Halted: enable is ignored; leaving one-shot mode releases the halt.
      r_tc <= 1'b0;
      if (mode != MODE_ONESHOT) begin
        r_state <= ST_RUN;
      end else begin
        r_state <= ST_HALT;
      end
    end else if (enable) begin
      r_count <= w_next_count;
      r_tc    <= w_tc_next;
      if (w_hit_boundary && (mode == MODE_ONESHOT)) begin
        r_state <= ST_HALT;
      end else begin
        r_state <= ST_RUN;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign done    = (r_state == ST_HALT);
  assign at_min  = (r_count == lim_min);
  assign at_max  = (r_count == lim_max);
  assign cfg_err = w_cfg_err;

endmodule

// File: doc/up_down_limit_counter.md
Name: up_down_limit_counter

Overview:
- Parametrised up/down counter with load, a programmable step, and programmable lower/upper limits.
- Three boundary modes: wrap, saturate, one-shot. Produces a registered terminal-count pulse and status flags.
- Drop-in successor to the plain up/down/load counter for timers, address generators and PWM period counters in the datapath.

Parameters:
WIDTH, 8, counter/limit/load width in bits
STEP_W, 4, width of the step input; must satisfy STEP_W <= WIDTH

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  count enable; advance by step when high
clear  input  1  synchronous clear to lim_min (up) or lim_max (down)
load  input  1  synchronous load of load_value
up  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment magnitude, unsigned
load_value  input  WIDTH  value for load
lim_min  input  WIDTH  lower limit, inclusive, unsigned
lim_max  input  WIDTH  upper limit, inclusive, unsigned
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (acts as wrap)
count  output  WIDTH  current count (registered)
tc  output  1  one-cycle terminal-count pulse (registered)
at_min  output  1  count == lim_min (combinational from count)
at_max  output  1  count == lim_max (combinational from count)
done  output  1  one-shot halted (state == HALT)
cfg_err  output  1  lim_min > lim_max (combinational)

Behaviour:
- Reset (reset_n low, async): count = 0, tc = 0, state = RUN. done = 0. at_min/at_max/cfg_err follow inputs.
- Priority per clock edge: clear > load > enable step > hold.
- cfg_err = 1: count holds, tc = 0, state unchanged. clear and load are also ignored.
- clear: count = up ? lim_min : lim_max; state = RUN; tc = 0.
- load: count = load_value clamped to [lim_min, lim_max]; state = RUN; tc = 0. up is don't-care.
- step == 0 with enable: count holds, tc = 0.
- Step arithmetic: computed in WIDTH+1 bits. Up: sum = count + step; boundary when sum >= lim_max. Down: diff = count - step; boundary when diff <= lim_min, including borrow below 0.
- Non-boundary step: count = sum/diff; tc = 0.
- Boundary, up direction (overshoot remainder is discarded):
  - wrap: if count == lim_max, count = lim_min; otherwise count = lim_max. tc = 1 when the new count is lim_max or when wrapping.
  - saturate: count = lim_max. tc = 1 only on the step that reaches lim_max from below; 0 while held at lim_max.
  - one-shot: count = lim_max, state -> HALT, tc = 1.
- Boundary, down direction: symmetric, with lim_min in place of lim_max.
- tc is high for exactly the cycle after the triggering edge; never high for 2 consecutive cycles unless consecutive wraps occur.
- State machine (one-shot only):
  - RUN: normal stepping.
  - HALT: enable ignored, count holds, done = 1.
  - HALT -> RUN on clear, load, or mode != one-shot.
  - In non-one-shot modes, state stays RUN.
- Mid-run changes: changes to mode, limits or up take effect at the next edge. Count is not re-clamped when limits change; the next step or load normalises it.
- Reset asserted mid-operation: immediate return to reset values, independent of clk.

Decomposition:
- counter_pkg holds:
  - mode constants: MODE_WRAP = 2'b00, MODE_SAT = 2'b01, MODE_ONESHOT = 2'b10;
  - state encoding: ST_RUN = 1'b0, ST_HALT = 1'b1.
- One sub-module: up_down_limit_step_calc, purely combinational.
  - Inputs: count, step, up, limits, mode.
  - Outputs: next_count, hit_boundary, tc_next.
- Top module holds the registers, priority logic and FSM.

Test Plan:
- Wrap up, WIDTH=8, min=10, max=20, step=3, from load 10, enable 5 cycles -> 13,16,19,20(tc),10(tc); at_max high while count=20.
- Saturate down, min=5, max=50, step=4, load 12, enable 4 cycles -> 8,5(tc),5,5; tc high only once; at_min stays high.
- One-shot up, min=0, max=7, step=2, clear, enable 5 cycles -> 2,4,6,7(tc,done=1),7. Then load 3 -> count=3, done=0, counting resumes.
- Priority and clamp, min=10, max=20:
  - clear+load+enable same edge with up=1 -> count=10.
  - load 250 -> count=20.
  - load 2 -> count=10.
  - step=0 with enable -> holds, tc=0.
- cfg_err: min=30, max=20 -> cfg_err=1; enable/load/clear do not change count.
- Async reset: assert reset_n mid-cycle while counting -> count=0, tc=0, done=0 before the next clk edge. Release, then enable -> stepping resumes from 0.
